lc3_datapath_checker: RTL and testbench

- Synthesizable run-time checker for the LC-3 datapath. Generalises the property checks to a parametrised bus width and driver count.
- Every cycle it checks:
  - bus-driver exclusivity;
  - bus-vs-source agreement;
  - NZP flag update and one-hotness;
  - post-reset PC/IR state.
- Results appear as per-class error pulses, sticky flags, a saturating error counter, and a first-error capture record.
- Sits beside the datapath in the top level, observing only. Usable in FPGA builds where SVA is unavailable.

---
 rtl/lc3_datapath_checker_if.sv | 35 +++
 rtl/lc3_datapath_checker.sv | 158 +++++++++++++++
 tb/tb_lc3_datapath_checker.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_datapath_checker_if.sv
// ----------------------------------------------------------------------------
// lc3_datapath_checker_if
// Bundles the LC-3 datapath signals that the run-time checker observes.
//   ena      : per-driver tri-state enables (bit order ALU, MARM, PC, MDR)
//   src_data : driver outputs, source i at [i*WIDTH +: WIDTH]
//   buss     : shared bus value
//   flag_we  : NZP register write enable
//   n, z, p  : condition flags
//   pc_out   : PC register value
//   ir       : IR register value
// master : the datapath side (drives everything)
// slave  : the checker side (observes everything)
// ----------------------------------------------------------------------------
interface lc3_datapath_checker_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4
);
  logic [NSRC-1:0]       ena;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]      buss;
  logic                  flag_we;
  logic                  n;
  logic                  z;
  logic                  p;
  logic [WIDTH-1:0]      pc_out;
  logic [WIDTH-1:0]      ir;

  modport master (
    output ena, src_data, buss, flag_we, n, z, p, pc_out, ir
  );

  modport slave (
    input ena, src_data, buss, flag_we, n, z, p, pc_out, ir
  );
endinterface

// File: rtl/lc3_datapath_checker.sv
// ----------------------------------------------------------------------------
// lc3_datapath_checker
// Synthesizable run-time checker for the LC-3 datapath. Observes the datapath
// every cycle and flags four violation classes:
//   bit0 DRV  : more than one bus driver enabled
//   bit1 BUS  : an enabled driver disagrees with the bus value
//   bit2 FLAG : NZP not one-hot, or NZP differs from the value implied by the
//               bus on the previous flag write
//   bit3 RST  : PC or IR nonzero on the first cycle after reset release
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   chk_en       : 1 = record violations, 0 = ignore (tracking continues)
//   clr          : synchronous clear of sticky, counter and first-error record
//   dp           : observed datapath signals (slave modport)
//   err_pulse    : violations detected in the previous cycle
//   err_sticky   : OR of all err_pulse since last rst/clr
//   err_count    : saturating count of cycles with at least one violation
//   first_valid  : first-error record is valid
//   first_class  : err_pulse mask of the first violating cycle
//   first_src    : lowest mismatching source at the first BUS error, else 0
//   first_time   : timestamp of the first violating cycle
// ----------------------------------------------------------------------------
module lc3_datapath_checker #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 4,
  parameter int CNT_W = 8,
  parameter int TS_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     chk_en,
  input  logic                     clr,
  lc3_datapath_checker_if.slave    dp,
  output logic [3:0]               err_pulse,
  output logic [3:0]               err_sticky,
  output logic [CNT_W-1:0]         err_count,
  output logic                     first_valid,
  output logic [3:0]               first_class,
  output logic [$clog2(NSRC)-1:0]  first_src,
  output logic [TS_W-1:0]          first_time
);

  localparam int SRC_W = $clog2(NSRC);

  // State
  logic              rst_d_q;
  logic [TS_W-1:0]   ts_q;
  logic              exp_valid_q;
  logic [2:0]        exp_nzp_q;
  logic [3:0]        pulse_q,       pulse_d;
  logic [3:0]        sticky_q,      sticky_d;
  logic [CNT_W-1:0]  count_q,       count_d;
  logic              first_valid_q, first_valid_d;
  logic [3:0]        first_class_q, first_class_d;
  logic [SRC_W-1:0]  first_src_q,   first_src_d;
  logic [TS_W-1:0]   first_time_q,  first_time_d;

  // Per-source disagreement with the bus, only for enabled drivers
  logic [NSRC-1:0] mism;
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_mism
      assign mism[gi] = dp.ena[gi] && (dp.src_data[gi*WIDTH +: WIDTH] != dp.buss);
    end
  endgenerate

  // Lowest mismatching index: scan high-to-low so the lowest hit wins
  logic [SRC_W-1:0] low_idx;
  always_comb begin
    low_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (mism[i]) low_idx = SRC_W'(i);
    end
  end

  // NZP implied by the current bus value (signed interpretation)
  logic [2:0] nzp_now;
  logic [2:0] nzp_bus;
  assign nzp_now = {dp.n, dp.z, dp.p};
  assign nzp_bus = {dp.buss[WIDTH-1],
                    dp.buss == '0,
                    !dp.buss[WIDTH-1] && (dp.buss != '0)};

  logic drv_err, bus_err, flag_err, rst_err;
  logic [3:0] mask;
  assign drv_err  = $countones(dp.ena) > 1;
  assign bus_err  = |mism;
  assign flag_err = ($countones(nzp_now) > 1) ||
                    (exp_valid_q && (nzp_now != exp_nzp_q));
  assign rst_err  = rst_d_q && !rst && ((dp.pc_out != '0) || (dp.ir != '0));
  assign mask     = (rst || !chk_en) ? 4'b0000
                                     : {rst_err, flag_err, bus_err, drv_err};

  // Record update; clr wipes the history first so a same-cycle violation
  // becomes the new first record.
  logic              fv_base;
  logic [CNT_W-1:0]  cnt_base;
  always_comb begin
    fv_base  = clr ? 1'b0 : first_valid_q;
    cnt_base = clr ? '0 : count_q;

    pulse_d  = mask;
    sticky_d = (clr ? 4'b0000 : sticky_q) | mask;

    count_d = cnt_base;
    if ((mask != 4'b0000) && (cnt_base != {CNT_W{1'b1}})) begin
      count_d = cnt_base + 1'b1;
    end

    first_valid_d = fv_base;
    first_class_d = clr ? 4'b0000 : first_class_q;
    first_src_d   = clr ? '0 : first_src_q;
    first_time_d  = clr ? '0 : first_time_q;
    if (!fv_base && (mask != 4'b0000)) begin
      first_valid_d = 1'b1;
      first_class_d = mask;
      first_src_d   = mask[1] ? low_idx : '0;
      first_time_d  = ts_q;
    end
  end

  always_ff @(posedge clk) begin
    rst_d_q <= rst;
    if (rst) begin
      ts_q          <= '0;
      exp_valid_q   <= 1'b0;
      exp_nzp_q     <= 3'b000;
      pulse_q       <= 4'b0000;
      sticky_q      <= 4'b0000;
      count_q       <= '0;
      first_valid_q <= 1'b0;
      first_class_q <= 4'b0000;
      first_src_q   <= '0;
      first_time_q  <= '0;
    end else begin
      ts_q          <= ts_q + 1'b1;
      // Expectation tracks flag writes regardless of chk_en
      exp_valid_q   <= dp.flag_we;
      if (dp.flag_we) exp_nzp_q <= nzp_bus;
      pulse_q       <= pulse_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
      first_valid_q <= first_valid_d;
      first_class_q <= first_class_d;
      first_src_q   <= first_src_d;
      first_time_q  <= first_time_d;
    end
  end

  assign err_pulse   = pulse_q;
  assign err_sticky  = sticky_q;
  assign err_count   = count_q;
  assign first_valid = first_valid_q;
  assign first_class = first_class_q;
  assign first_src   = first_src_q;
  assign first_time  = first_time_q;

endmodule

// File: tb/tb_lc3_datapath_checker.sv
// ----------------------------------------------------------------------------
// tb_lc3_datapath_checker
// Directed stimulus with a reference model feeding a scoreboard queue: each
// cycle the expected outputs are pushed when inputs are driven and popped
// after the clock edge for comparison. Extra directed checks pin down the
// specific values called out for each scenario.
// ----------------------------------------------------------------------------
module tb_lc3_datapath_checker;

  localparam int WIDTH = 16;
  localparam int NSRC  = 4;
  localparam int CNT_W = 8;
  localparam int TS_W  = 32;

  logic clk = 1'b0;
  logic rst, chk_en, clr;
  logic [3:0]       err_pulse, err_sticky, first_class;
  logic [CNT_W-1:0] err_count;
  logic             first_valid;
  logic [1:0]       first_src;
  logic [TS_W-1:0]  first_time;

  lc3_datapath_checker_if #(.WIDTH(WIDTH), .NSRC(NSRC)) dp_if ();

  lc3_datapath_checker #(.WIDTH(WIDTH), .NSRC(NSRC), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .chk_en      (chk_en),
    .clr         (clr),
    .dp          (dp_if),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .first_valid (first_valid),
    .first_class (first_class),
    .first_src   (first_src),
    .first_time  (first_time)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       pulse;
    logic [3:0]       sticky;
    logic [CNT_W-1:0] count;
    logic             fv;
    logic [3:0]       cls;
    logic [1:0]       src;
    logic [TS_W-1:0]  tstamp;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state
  logic        m_rst_d = 1'b0;
  int unsigned m_ts = 0;
  logic        m_exp_valid = 1'b0;
  logic [2:0]  m_exp_nzp = 3'b000;
  exp_t        m = '0;
  int          m_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_src(input int i, input logic [WIDTH-1:0] v);
    dp_if.src_data[i*WIDTH +: WIDTH] = v;
  endtask

  // Compute the expected outcome of the current inputs, push it, clock once,
  // then pop and compare against the DUT.
  task automatic cycle(input string tag);
    int          drivers;
    logic        drv, bus, flg, rse;
    int          lowest;
    logic [3:0]  mask;
    logic signed [WIDTH-1:0] sb;
    logic [2:0]  nzp;
    exp_t        e;

    drivers = 0;
    bus = 1'b0;
    lowest = 0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (dp_if.ena[i]) begin
        drivers++;
        if (dp_if.src_data[i*WIDTH +: WIDTH] !== dp_if.buss) begin
          bus = 1'b1;
          lowest = i;
        end
      end
    end
    drv = (drivers >= 2);
    nzp = {dp_if.n, dp_if.z, dp_if.p};
    flg = (int'(dp_if.n) + int'(dp_if.z) + int'(dp_if.p) >= 2) ||
          (m_exp_valid && (nzp !== m_exp_nzp));
    rse = m_rst_d && !rst && ((dp_if.pc_out | dp_if.ir) != 0);
    mask = (rst || !chk_en) ? 4'b0000 : {rse, flg, bus, drv};

    if (rst) begin
      m = '0;
      m_count = 0;
      m_ts = 0;
      m_exp_valid = 1'b0;
      m_exp_nzp = 3'b000;
    end else begin
      if (clr) begin
        m = '0;
        m_count = 0;
      end
      m.pulse = mask;
      m.sticky = m.sticky | mask;
      if (mask != 0 && m_count < 255) m_count++;
      m.count = m_count[CNT_W-1:0];
      if (!m.fv && mask != 0) begin
        m.fv = 1'b1;
        m.cls = mask;
        m.src = bus ? 2'(lowest) : 2'd0;
        m.tstamp = m_ts;
      end
      m_ts++;
      m_exp_valid = dp_if.flag_we;
      if (dp_if.flag_we) begin
        sb = dp_if.buss;
        if (sb < 0)       m_exp_nzp = 3'b100;
        else if (sb == 0) m_exp_nzp = 3'b010;
        else              m_exp_nzp = 3'b001;
      end
    end
    m_rst_d = rst;
    sb_q.push_back(m);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".pulse"},  32'(err_pulse),   32'(e.pulse));
    chk({tag, ".sticky"}, 32'(err_sticky),  32'(e.sticky));
    chk({tag, ".count"},  32'(err_count),   32'(e.count));
    chk({tag, ".fvalid"}, 32'(first_valid), 32'(e.fv));
    chk({tag, ".fclass"}, 32'(first_class), 32'(e.cls));
    chk({tag, ".fsrc"},   32'(first_src),   32'(e.src));
    chk({tag, ".ftime"},  32'(first_time),  e.tstamp);
    $display("[TB] %s ena=%b buss=%h nzp=%b rst=%b clr=%b en=%b -> pulse=%b sticky=%b cnt=%0d",
             tag, dp_if.ena, dp_if.buss, nzp, rst, clr, chk_en, err_pulse, err_sticky, err_count);
  endtask

  task automatic idle_inputs();
    dp_if.ena = '0;
    dp_if.src_data = '0;
    dp_if.buss = '0;
    dp_if.flag_we = 1'b0;
    dp_if.n = 1'b0;
    dp_if.z = 1'b0;
    dp_if.p = 1'b0;
    dp_if.pc_out = '0;
    dp_if.ir = '0;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    chk_en = 1'b1;
    idle_inputs();

    // Reset and clean release
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0;
    cycle("release_clean");
    chk("clean_no_rst_pulse", 32'(err_pulse), 32'h0);

    // Release with nonzero IR
    rst = 1'b1;
    cycle("reset2");
    cycle("reset3");
    rst = 1'b0;
    dp_if.ir = 16'h1234;
    cycle("release_ir");
    chk("rst_pulse", 32'(err_pulse), 32'h8);
    chk("rst_first_class", 32'(first_class), 32'h8);
    chk("rst_first_time", first_time, 32'd0);
    dp_if.ir = 16'h0000;
    cycle("after_ir");

    // DRV at ts=10
    rst = 1'b1;
    cycle("reset4");
    rst = 1'b0;
    while (m_ts != 10) cycle("idle");
    dp_if.ena = 4'b0101;
    cycle("drv_ts10");
    chk("drv_pulse", 32'(err_pulse), 32'h1);
    chk("drv_sticky", 32'(err_sticky), 32'h1);
    chk("drv_count", 32'(err_count), 32'd1);
    chk("drv_first_time", first_time, 32'd10);
    dp_if.ena = 4'b0000;
    cycle("drv_gone");
    chk("drv_pulse_once", 32'(err_pulse), 32'h0);

    // BUS mismatch on the PC driver
    clr = 1'b1;
    cycle("clr0");
    clr = 1'b0;
    dp_if.ena = 4'b0100;
    set_src(2, 16'h3000);
    dp_if.buss = 16'h3001;
    cycle("bus_pc");
    chk("bus_pulse", 32'(err_pulse), 32'h2);
    chk("bus_first_src", 32'(first_src), 32'd2);
    dp_if.ena = 4'b0000;
    dp_if.buss = 16'hBEEF;
    cycle("bus_none");
    chk("bus_no_driver", 32'(err_pulse), 32'h0);

    // NZP expectation
    clr = 1'b1;
    dp_if.buss = 16'h8000;
    dp_if.flag_we = 1'b1;
    cycle("flag_we_neg");
    clr = 1'b0;
    dp_if.flag_we = 1'b0;
    dp_if.n = 1'b1;
    cycle("flag_n_ok");
    chk("flag_neg_ok", 32'(err_pulse), 32'h0);
    dp_if.n = 1'b0;
    dp_if.buss = 16'h0000;
    dp_if.flag_we = 1'b1;
    cycle("flag_we_zero");
    dp_if.flag_we = 1'b0;
    dp_if.p = 1'b1;
    cycle("flag_p_bad");
    chk("flag_zero_mismatch", 32'(err_pulse), 32'h4);
    dp_if.buss = 16'h7FFF;
    dp_if.flag_we = 1'b1;
    cycle("flag_we_pos");
    dp_if.flag_we = 1'b0;
    cycle("flag_p_ok");
    chk("flag_pos_ok", 32'(err_pulse), 32'h0);
    dp_if.n = 1'b1;
    dp_if.z = 1'b1;
    dp_if.p = 1'b0;
    cycle("flag_nz");
    chk("flag_not_onehot", 32'(err_pulse), 32'h4);
    dp_if.n = 1'b0;
    dp_if.z = 1'b0;

    // Counter saturation
    clr = 1'b1;
    cycle("clr1");
    clr = 1'b0;
    dp_if.buss = 16'h0000;
    dp_if.ena = 4'b0011;
    for (int k = 0; k < 300; k++) cycle("drv_burst");
    chk("count_saturated", 32'(err_count), 32'd255);

    // clr together with a BUS violation
    clr = 1'b1;
    dp_if.ena = 4'b0001;
    set_src(0, 16'h0001);
    cycle("clr_bus");
    clr = 1'b0;
    chk("clr_bus_count", 32'(err_count), 32'd1);
    chk("clr_bus_sticky", 32'(err_sticky), 32'h2);
    chk("clr_bus_class", 32'(first_class), 32'h2);
    set_src(0, 16'h0000);

    // chk_en low during DRV
    chk_en = 1'b0;
    dp_if.ena = 4'b0011;
    cycle("drv_disabled");
    chk("disabled_pulse", 32'(err_pulse), 32'h0);
    chk("disabled_count", 32'(err_count), 32'd1);
    chk_en = 1'b1;
    cycle("drv_burst2a");
    cycle("drv_burst2b");
    rst = 1'b1;
    cycle("rst_mid_burst");
    chk("rst_mid_count", 32'(err_count), 32'd0);
    chk("rst_mid_sticky", 32'(err_sticky), 32'h0);
    rst = 1'b0;
    dp_if.ena = 4'b0000;
    cycle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
